// File: rtl/forex_update_sequencer.sv
// Avalon-MM front end: stages edge updates in a FIFO, streams them to the graph core, then runs it.
// Reads return one cycle after the strobe; the update stream stalls on upd_ready and full-FIFO pushes drop with a sticky flag.
module forex_update_sequencer #(
  parameter int NODE_W   = 3,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [NODE_W-1:0]   upd_src,
  output logic [NODE_W-1:0]   upd_dst,
  output logic [WEIGHT_W-1:0] upd_weight,
  output logic                core_start,
  input  logic                core_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 * NODE_W + WEIGHT_W;
  localparam int RC_W  = (DATA_W - 16 < 16) ? DATA_W - 16 : 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                run_pending_q, run_pending_d;
  logic [15:0]         run_count_q, run_count_d;
  logic                overflow_q, overflow_d;
  logic [NODE_W-1:0]   stage_src_q, stage_src_d;
  logic [NODE_W-1:0]   stage_dst_q, stage_dst_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;

  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                wr_en, rd_en;
  logic                wr_stage, wr_push, wr_ctrl;
  logic                run_req, flush_req, ovf_clr;
  logic                fifo_full, pop, push_ok, push_drop;
  logic [ENT_W-1:0]    head;
  logic [DATA_W-1:0]   status_word, stage_word;

  // Bus decode
  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign wr_stage  = wr_en && (address == 3'd0);
  assign wr_push   = wr_en && (address == 3'd1);
  assign wr_ctrl   = wr_en && (address == 3'd2);
  assign run_req   = wr_ctrl & writedata[0];
  assign flush_req = wr_ctrl & writedata[1] & (state_q == IDLE);
  assign ovf_clr   = wr_ctrl & writedata[2];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign fifo_full = (count_q == CNT_W'(DEPTH));
  assign pop       = upd_valid & upd_ready;
  assign push_ok   = wr_push & (~fifo_full | pop);
  assign push_drop = wr_push & fifo_full & ~pop;

  assign head       = mem_q[rd_ptr_q];
  assign upd_src    = head[ENT_W-1 -: NODE_W];
  assign upd_dst    = head[WEIGHT_W +: NODE_W];
  assign upd_weight = head[WEIGHT_W-1:0];

  assign busy     = (state_q != IDLE);
  assign readdata = readdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok && !flush_req)
        mem_q[wr_ptr_q] <= {stage_src_q, stage_dst_q, writedata[WEIGHT_W-1:0]};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A run snapshots the FIFO depth, so entries pushed while draining wait for the next run.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    run_pending_d = run_pending_q;
    run_count_d   = run_count_q;
    upd_valid     = 1'b0;
    core_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_pending_q) begin
          run_pending_d = 1'b0;
          remaining_d   = count_q;
          state_d       = (count_q == '0) ? START : DRAIN;
        end
      end
      DRAIN: begin
        upd_valid = (remaining_q != '0);
        if (remaining_q == '0) begin
          state_d = START;
        end else if (upd_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          run_count_d = run_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (run_req) run_pending_d = 1'b1;
  end

  always_comb begin
    overflow_d  = overflow_q;
    stage_src_d = stage_src_q;
    stage_dst_d = stage_dst_q;
    if (push_drop) overflow_d = 1'b1;
    if (ovf_clr)   overflow_d = 1'b0;
    if (wr_stage) begin
      stage_src_d = writedata[2*NODE_W-1:NODE_W];
      stage_dst_d = writedata[NODE_W-1:0];
    end
  end

  always_comb begin
    status_word                   = '0;
    status_word[CNT_W-1:0]        = count_q;
    status_word[13]               = busy;
    status_word[14]               = run_pending_q;
    status_word[15]               = overflow_q;
    status_word[16 +: RC_W]       = run_count_q[RC_W-1:0];
    stage_word                    = '0;
    stage_word[2*NODE_W-1:0]      = {stage_src_q, stage_dst_q};
    readdata_d                    = readdata_q;
    if (rd_en) begin
      case (address)
        3'd3:    readdata_d = status_word;
        3'd4:    readdata_d = stage_word;
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      run_pending_q <= 1'b0;
      run_count_q   <= '0;
      overflow_q    <= 1'b0;
      stage_src_q   <= '0;
      stage_dst_q   <= '0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      run_pending_q <= run_pending_d;
      run_count_q   <= run_count_d;
      overflow_q    <= overflow_d;
      stage_src_q   <= stage_src_d;
      stage_dst_q   <= stage_dst_d;
      readdata_q    <= readdata_d;
    end
  end

endmodule

// File: doc/forex_update_sequencer.md
Name: forex_update_sequencer

Overview:
- Parametrised Avalon-MM front-end for the arbitrage engine.
- Software writes edge updates (src, dst, weight). They are queued in an internal FIFO, then streamed to the graph core over a valid/ready port.
- The sequencer pulses the core start, waits for done and reports status and run count.
- Adds to the previous single-register peripheral: buffering, backpressure, overflow detection, run queuing and a readable status path.

Parameters:
- NODE_W, 3, node index width (bits) for src and dst.
- WEIGHT_W, 32, edge weight width (bits); must be ≤ DATA_W.
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- DATA_W, 32, Avalon data width; must be ≥ 2*NODE_W and ≥ 16+CNT_W.
- CNT_W = log2(DEPTH)+1 (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data, valid 1 cycle after read
- upd_valid  out  1  update entry presented to core
- upd_ready  in  1  core accepts entry
- upd_src  out  NODE_W  edge source
- upd_dst  out  NODE_W  edge destination
- upd_weight  out  WEIGHT_W  edge weight
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  core finished; level or pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert; release synchronous to clk):
  - state=IDLE, FIFO empty, staging regs 0, overflow=0, run_pending=0, run_count=0.
  - upd_valid=0, core_start=0, busy=0, readdata=0.
- Register map (access with chipselect high):
  - addr0 W: stage src=writedata[2*NODE_W-1:NODE_W], dst=writedata[NODE_W-1:0].
  - addr1 W: push {staged src, staged dst, writedata[WEIGHT_W-1:0]} into FIFO. Staged src/dst are retained after the push.
  - addr2 W control:
    - bit0 = run request.
    - bit1 = flush FIFO; ignored unless state=IDLE.
    - bit2 = clear overflow.
  - addr3 R status: {run_count[15:0] in [31:16], overflow [15], run_pending [14], busy [13], count in [CNT_W-1:0]}.
  - addr4 R: staged {src,dst}, right-aligned.
  - Other addresses: writes ignored, reads return 0.
- FIFO:
  - Push when full with no same-cycle pop: entry dropped, overflow set (sticky).
  - Push and pop in the same cycle: both succeed, including when full; count unchanged.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
  - Head entry drives upd_* combinationally from storage. Pop occurs when upd_valid && upd_ready.
- FSM:
  - IDLE:
    - On run request or run_pending: snapshot remaining=count, clear run_pending, go to DRAIN.
    - If remaining=0, go directly to START.
  - DRAIN:
    - upd_valid=1 while remaining>0; each handshake decrements remaining.
    - Go to START on the cycle the last handshake completes.
    - Entries pushed during DRAIN are not part of this run.
  - START: core_start=1 for exactly one cycle; go to WAIT.
  - WAIT:
    - On core_done=1: run_count+1 (wraps at 2^16), go to IDLE.
    - core_done is ignored in every state other than WAIT.
- Run request while busy: sets run_pending (one level deep; further requests are lost, no error). Serviced on the first IDLE cycle.
- Simultaneous run request and flush in IDLE: flush applies first, so the run snapshots count=0.
- upd_valid=0 outside DRAIN. upd_* values hold the head entry regardless of upd_valid.
- Reset asserted mid-run:
  - Immediate return to IDLE, FIFO contents lost, outputs at reset values.
  - A core_done arriving after reset is ignored.

Test Plan:
1. Write addr0=0x0000_0015 (src=2, dst=5), addr1=0x0000_0100, then addr2=1 with upd_ready tied 1 -> one upd_valid cycle showing src=2, dst=5, weight=0x100; core_start pulse on the next cycle; core_done after 10 cycles -> busy=0 and addr3 reads run_count=1, count=0.
2. Push 17 entries with DEPTH=16 -> count=16, overflow=1; write addr2=4 -> overflow=0; the 17th entry never appears on upd_*.
3. upd_ready toggling 1,0,0,1 over 3 queued entries -> entries delivered in push order, no duplicates or drops; DRAIN lasts ≥5 cycles.
4. During WAIT, push 2 entries and write addr2=1 twice -> run_pending=1. After core_done, a second run drains exactly 2 entries; run_count reaches 2, not 3.
5. Assert reset asynchronously, mid-cycle, during DRAIN with 5 entries left -> upd_valid, busy and count are 0 immediately; a later core_done produces no run_count change.
6. Flush and run in the same write (addr2=3) with 4 queued entries -> no upd_valid; core_start pulses 2 cycles later; count=0.
